// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two valid/ready requesters
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [DATA_W-1:0] a_op1,
  input  logic [DATA_W-1:0] a_op2,
  input  logic [CTRL_W-1:0] a_ctrl,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [DATA_W-1:0] a_rsp_result,
  output logic              a_rsp_zero,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [DATA_W-1:0] b_op1,
  input  logic [DATA_W-1:0] b_op2,
  input  logic [CTRL_W-1:0] b_ctrl,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] b_rsp_result,
  output logic              b_rsp_zero,
  output logic              last_grant,
  output logic [CNT_W-1:0]  ops_done
);
  logic elig_a, elig_b, grant_a, grant_b, ptr;
  logic [DATA_W-1:0] op1, op2, res;
  logic [CTRL_W-1:0] ctrl;
  logic [4:0] sh;
  // a side holding an unconsumed response cannot be granted, so results are never overwritten
  assign elig_a  = a_req_valid && (!a_rsp_valid || a_rsp_ready);
  assign elig_b  = b_req_valid && (!b_rsp_valid || b_rsp_ready);
  assign grant_a = elig_a && (!elig_b || !ptr);
  assign grant_b = elig_b && (!elig_a || ptr);
  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign op1  = grant_b ? b_op1 : a_op1;
  assign op2  = grant_b ? b_op2 : a_op2;
  assign ctrl = grant_b ? b_ctrl : a_ctrl;
  assign sh   = op2[4:0];
  always_comb begin
    res = '0;
    case (ctrl)
      CTRL_W'(0):  res = op1 + op2;
      CTRL_W'(8):  res = op1 - op2;
      CTRL_W'(4):  res = op1 ^ op2;
      CTRL_W'(6):  res = op1 | op2;
      CTRL_W'(7):  res = op1 & op2;
      CTRL_W'(1):  res = op1 << sh;
      CTRL_W'(5):  res = op1 >> sh;
      CTRL_W'(13): res = $signed(op1) >>> sh;
      CTRL_W'(2):  res = {{(DATA_W-1){1'b0}}, $signed(op1) < $signed(op2)};
      CTRL_W'(3):  res = {{(DATA_W-1){1'b0}}, op1 < op2};
      default:     res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rsp_valid  <= 1'b0;
      a_rsp_result <= '0;
      a_rsp_zero   <= 1'b0;
      b_rsp_valid  <= 1'b0;
      b_rsp_result <= '0;
      b_rsp_zero   <= 1'b0;
      ptr          <= 1'b0;
      last_grant   <= 1'b0;
      ops_done     <= '0;
    end else begin
      if (grant_a) begin
        a_rsp_valid  <= 1'b1;
        a_rsp_result <= res;
        a_rsp_zero   <= (res == '0);
      end else if (a_rsp_ready) a_rsp_valid <= 1'b0;
      if (grant_b) begin
        b_rsp_valid  <= 1'b1;
        b_rsp_result <= res;
        b_rsp_zero   <= (res == '0);
      end else if (b_rsp_ready) b_rsp_valid <= 1'b0;
      if (grant_a || grant_b) begin
        ptr        <= grant_a;
        last_grant <= grant_b;
        ops_done   <= ops_done + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic a_req_valid = 0, a_req_ready, a_rsp_valid, a_rsp_ready = 0, a_rsp_zero;
  logic b_req_valid = 0, b_req_ready, b_rsp_valid, b_rsp_ready = 0, b_rsp_zero;
  logic [31:0] a_op1 = 0, a_op2 = 0, b_op1 = 0, b_op2 = 0, a_rsp_result, b_rsp_result;
  logic [3:0] a_ctrl = 0, b_ctrl = 0, ops_done;
  logic last_grant;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op1(a_op1), .a_op2(a_op2),
    .a_ctrl(a_ctrl), .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .a_rsp_result(a_rsp_result), .a_rsp_zero(a_rsp_zero),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op1(b_op1), .b_op2(b_op2),
    .b_ctrl(b_ctrl), .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .b_rsp_result(b_rsp_result), .b_rsp_zero(b_rsp_zero),
    .last_grant(last_grant), .ops_done(ops_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] sw_ctrl [9];
    logic [31:0] sw_res [9];
    sw_ctrl = '{13, 5, 1, 2, 3, 15, 4, 6, 7};
    sw_res  = '{32'hF8000000, 32'h08000000, 0, 1, 0, 0, 32'h80000004, 32'h80000004, 0};
    do_reset();
    #1;
    chk("rst_a_valid", a_rsp_valid, 0);
    chk("rst_a_result", a_rsp_result, 0);
    chk("rst_a_zero", a_rsp_zero, 0);
    chk("rst_b_valid", b_rsp_valid, 0);
    chk("rst_b_result", b_rsp_result, 0);
    chk("rst_last_grant", last_grant, 0);
    chk("rst_ops_done", ops_done, 0);
    // A alone: add 5+7
    @(negedge clk);
    a_req_valid = 1; a_op1 = 5; a_op2 = 7; a_ctrl = 0;
    #1 chk("a_only_ready", a_req_ready, 1);
    edge_tick();
    a_req_valid = 0;
    chk("a_only_valid", a_rsp_valid, 1);
    chk("a_only_result", a_rsp_result, 12);
    chk("a_only_zero", a_rsp_zero, 0);
    chk("a_only_ops", ops_done, 1);
    chk("a_only_lg", last_grant, 0);
    @(negedge clk);
    a_rsp_ready = 1;
    edge_tick();
    chk("a_consume_valid", a_rsp_valid, 0);
    chk("a_consume_hold", a_rsp_result, 12);
    // contention from a fresh reset
    do_reset();
    a_req_valid = 1; a_op1 = 9; a_op2 = 9; a_ctrl = 8; a_rsp_ready = 1;
    b_req_valid = 1; b_op1 = 1; b_op2 = 32'hFFFFFFFF; b_ctrl = 3; b_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_a_ready", a_req_ready, (i % 2 == 0));
      chk("cont_b_ready", b_req_ready, (i % 2 == 1));
      edge_tick();
      chk("cont_lg", last_grant, (i % 2 == 1));
      if (i % 2 == 0) begin
        chk("cont_a_valid", a_rsp_valid, 1);
        chk("cont_a_result", a_rsp_result, 0);
        chk("cont_a_zero", a_rsp_zero, 1);
      end else begin
        chk("cont_b_valid", b_rsp_valid, 1);
        chk("cont_b_result", b_rsp_result, 1);
        chk("cont_b_zero", b_rsp_zero, 0);
        chk("cont_a_cleared", a_rsp_valid, 0);
      end
      @(negedge clk);
    end
    chk("cont_ops", ops_done, 4);
    // backpressure on B: pending result 1, new B op sltu 5<3 = 0
    b_rsp_ready = 0; b_op1 = 5; b_op2 = 3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_b_ready", b_req_ready, 0);
      chk("bp_a_ready", a_req_ready, 1);
      edge_tick();
      chk("bp_b_result", b_rsp_result, 1);
      chk("bp_b_valid", b_rsp_valid, 1);
      @(negedge clk);
    end
    b_rsp_ready = 1;
    #1;
    chk("bp_release_b", b_req_ready, 1);
    chk("bp_release_a", a_req_ready, 0);
    edge_tick();
    chk("bp_new_result", b_rsp_result, 0);
    chk("bp_new_zero", b_rsp_zero, 1);
    chk("bp_new_valid", b_rsp_valid, 1);
    chk("bp_ops", ops_done, 10);
    b_req_valid = 0;
    // opcode sweep on A
    a_op1 = 32'h80000000; a_op2 = 4;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_ctrl = sw_ctrl[i][3:0];
      edge_tick();
      chk($sformatf("sweep_res_%0d", sw_ctrl[i]), a_rsp_result, sw_res[i]);
      chk($sformatf("sweep_zero_%0d", sw_ctrl[i]), a_rsp_zero, (sw_res[i] == 0));
    end
    // reset during a pending response
    @(negedge clk);
    a_req_valid = 1; a_op1 = 5; a_op2 = 7; a_ctrl = 0; a_rsp_ready = 0;
    edge_tick();
    a_req_valid = 0;
    chk("mid_pending", a_rsp_valid, 1);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("mid_valid", a_rsp_valid, 0);
    chk("mid_ops", ops_done, 0);
    chk("mid_result", a_rsp_result, 0);
    @(negedge clk);
    reset_n = 1;
    a_req_valid = 1; a_ctrl = 0; a_rsp_ready = 1;
    b_req_valid = 1; b_ctrl = 0; b_rsp_ready = 1;
    #1;
    chk("post_rst_a", a_req_ready, 1);
    chk("post_rst_b", b_req_ready, 0);
    edge_tick();
    chk("post_rst_valid", a_rsp_valid, 1);
    chk("post_rst_result", a_rsp_result, 12);
    // counter wrap: 17 back-to-back A ops
    do_reset();
    a_req_valid = 1; a_rsp_ready = 1; a_ctrl = 0; a_op2 = 1;
    for (int i = 0; i < 17; i++) begin
      a_op1 = i;
      edge_tick();
      chk("wrap_valid", a_rsp_valid, 1);
      chk("wrap_result", a_rsp_result, i + 1);
      @(negedge clk);
    end
    a_req_valid = 0;
    chk("wrap_ops", ops_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
